bp_stall_counter_bank: RTL and testbench

// Downstream consumer of the core profiler's per-cycle stall classification.

---
 rtl/bp_stall_counter_bank.sv | 130 +++++++++++++
 tb/tb_bp_stall_counter_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_stall_counter_bank.sv
// Saturating live profiler counters (cycles, retired instructions, per-reason stalls)
// with an atomic shadow copy served to the host over a one-outstanding read handshake.
module bp_stall_counter_bank #(
    parameter int num_reasons_p = 32,
    parameter int cnt_width_p = 32,
    localparam int reason_width_lp = $clog2(num_reasons_p),
    localparam int addr_width_lp = $clog2(num_reasons_p + 2)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       freeze_i,
    input  logic                       commit_v_i,
    input  logic                       stall_v_i,
    input  logic [reason_width_lp-1:0] stall_reason_i,
    input  logic                       snap_i,
    input  logic                       clear_i,
    input  logic                       rd_v_i,
    input  logic [addr_width_lp-1:0]   rd_addr_i,
    output logic                       rd_ready_o,
    output logic                       rd_data_v_o,
    output logic [cnt_width_p-1:0]     rd_data_o,
    input  logic                       rd_data_yumi_i,
    output logic                       overflow_o
);

    localparam int num_cnt_lp = num_reasons_p + 2;

    typedef enum logic {e_idle, e_resp} state_e;

    logic [cnt_width_p-1:0] live_q   [num_cnt_lp];
    logic [cnt_width_p-1:0] live_d   [num_cnt_lp];
    logic [cnt_width_p-1:0] shadow_q [num_cnt_lp];
    logic [num_cnt_lp-1:0]  inc;
    logic [num_cnt_lp-1:0]  sat;
    logic                   overflow_q, overflow_d;
    state_e                 state_q, state_d;
    logic [cnt_width_p-1:0] rd_data_q, rd_data_d;
    logic [cnt_width_p-1:0] rd_sel;

    // Slot 0 = cycles, slot 1 = instrs, slot 2+k = reason k; commit shadows any stall.
    assign inc[0] = ~freeze_i;
    assign inc[1] = ~freeze_i & commit_v_i;

    genvar gi;
    generate
        for (gi = 0; gi < num_reasons_p; gi++) begin : g_reason_inc
            assign inc[gi+2] = ~freeze_i & ~commit_v_i & stall_v_i
                             & (stall_reason_i == reason_width_lp'(gi));
        end
        for (gi = 0; gi < num_cnt_lp; gi++) begin : g_sat
            assign sat[gi] = &live_q[gi];
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < num_cnt_lp; i++) begin
            live_d[i] = live_q[i];
            if (clear_i) begin
                live_d[i] = '0;
            end else if (inc[i] && !sat[i]) begin
                live_d[i] = live_q[i] + cnt_width_p'(1);
            end
        end
        overflow_d = clear_i ? 1'b0 : (overflow_q | (|(inc & sat)));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_cnt_lp; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < num_cnt_lp; i++) begin
                live_q[i] <= live_d[i];
                // Shadow captures this cycle's pre-increment, pre-clear values.
                if (snap_i) begin
                    shadow_q[i] <= live_q[i];
                end
            end
            overflow_q <= overflow_d;
        end
    end

    // Addresses beyond the last counter read as zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < num_cnt_lp; i++) begin
            if (rd_addr_i == addr_width_lp'(i)) begin
                rd_sel = shadow_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        case (state_q)
            e_idle: begin
                if (rd_v_i) begin
                    rd_data_d = rd_sel;
                    state_d   = e_resp;
                end
            end
            e_resp: begin
                if (rd_data_yumi_i) begin
                    state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_ready_o  = (state_q == e_idle);
    assign rd_data_v_o = (state_q == e_resp);
    assign rd_data_o   = rd_data_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_bp_stall_counter_bank.sv
// Bench for bp_stall_counter_bank: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural counter model.
module tb_bp_stall_counter_bank;

    localparam int NR = 12;
    localparam int CW = 8;
    localparam int NC = NR + 2;
    localparam int RW = $clog2(NR);
    localparam int AW = $clog2(NR + 2);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          freeze = 1'b0;
    logic          commit_v = 1'b0;
    logic          stall_v = 1'b0;
    logic [RW-1:0] stall_reason = '0;
    logic          snap = 1'b0;
    logic          clear = 1'b0;
    logic          rd_v = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ready;
    logic          rd_data_v;
    logic [CW-1:0] rd_data;
    logic          rd_yumi = 1'b0;
    logic          overflow;

    int total = 0;
    int bad = 0;

    bp_stall_counter_bank #(.num_reasons_p(NR), .cnt_width_p(CW)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .commit_v_i(commit_v),
        .stall_v_i(stall_v), .stall_reason_i(stall_reason), .snap_i(snap), .clear_i(clear),
        .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready), .rd_data_v_o(rd_data_v),
        .rd_data_o(rd_data), .rd_data_yumi_i(rd_yumi), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counters as plain integers capped at 2^CW-1.
    int  m_live   [NC];
    int  m_shadow [NC];
    int  m_data;
    bit  m_ovf;
    bit  m_resp;
    bit  chk_en = 1'b0;
    localparam int MAXV = (1 << CW) - 1;

    task automatic bump(input int idx);
        if (m_live[idx] == MAXV) m_ovf = 1'b1;
        else m_live[idx] = m_live[idx] + 1;
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NC; i++) begin
                m_live[i] = 0;
                m_shadow[i] = 0;
            end
            m_ovf = 1'b0;
            m_resp = 1'b0;
            m_data = 0;
        end else begin
            if (!m_resp) begin
                if (rd_v) begin
                    m_data = (int'(rd_addr) < NC) ? m_shadow[rd_addr] : 0;
                    m_resp = 1'b1;
                end
            end else if (rd_yumi) begin
                m_resp = 1'b0;
            end
            if (snap) begin
                for (int i = 0; i < NC; i++) m_shadow[i] = m_live[i];
            end
            if (clear) begin
                for (int i = 0; i < NC; i++) m_live[i] = 0;
                m_ovf = 1'b0;
            end else if (!freeze) begin
                bump(0);
                if (commit_v) bump(1);
                else if (stall_v && int'(stall_reason) < NR) bump(2 + int'(stall_reason));
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ready", 32'(rd_ready), 32'(!m_resp));
            check("model_valid", 32'(rd_data_v), 32'(m_resp));
            check("model_overflow", 32'(overflow), 32'(m_ovf));
            if (m_resp) check("model_data", 32'(rd_data), 32'(m_data));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int exp, input int hold);
        rd_v = 1'b1;
        rd_addr = a;
        cyc();
        rd_v = 1'b0;
        check("rd_valid_lat1", 32'(rd_data_v), 32'd1);
        check("rd_data", 32'(rd_data), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            cyc();
            check("hold_valid", 32'(rd_data_v), 32'd1);
            check("hold_ready", 32'(rd_ready), 32'd0);
            check("hold_data", 32'(rd_data), 32'(exp));
        end
        rd_yumi = 1'b1;
        cyc();
        rd_yumi = 1'b0;
        check("after_yumi_valid", 32'(rd_data_v), 32'd0);
    endtask

    task automatic pulse_snap();
        snap = 1'b1;
        cyc();
        snap = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        check("reset_ready", 32'(rd_ready), 32'd1);
        check("reset_valid", 32'(rd_data_v), 32'd0);
        check("reset_data", 32'(rd_data), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);

        // 10 idle cycles then snapshot
        reset_n = 1'b1;
        repeat (10) cyc();
        pulse_snap();
        do_read(AW'(0), 10, 0);
        do_read(AW'(1), 0, 0);

        // commit priority over stall, then pure stalls on reason 3
        pulse_clear();
        commit_v = 1'b1; stall_v = 1'b1; stall_reason = RW'(3);
        repeat (5) cyc();
        commit_v = 1'b0;
        repeat (4) cyc();
        stall_v = 1'b0;
        pulse_snap();
        do_read(AW'(1), 5, 0);
        do_read(AW'(5), 4, 0);

        // saturation of the cycle counter
        pulse_clear();
        repeat (MAXV - 1) cyc();
        cyc();
        check("at_max_no_ovf", 32'(overflow), 32'd0);
        cyc();
        check("ovf_set", 32'(overflow), 32'd1);
        pulse_snap();
        do_read(AW'(0), MAXV, 0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        pulse_clear();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // snap and clear together
        repeat (7) cyc();
        snap = 1'b1; clear = 1'b1;
        cyc();
        snap = 1'b0; clear = 1'b0;
        do_read(AW'(0), 7, 0);
        pulse_snap();
        do_read(AW'(0), 2, 0);

        // out-of-range address with a long response hold, then a nonzero hold
        do_read(AW'(NR + 3), 0, 5);
        do_read(AW'(0), 2, 5);

        // freeze with stalls and commits
        pulse_clear();
        repeat (3) cyc();
        freeze = 1'b1; stall_v = 1'b1;
        for (int i = 0; i < 20; i++) begin
            commit_v = ($urandom_range(0, 1) == 1);
            stall_reason = RW'($urandom_range(0, NR - 1));
            cyc();
        end
        freeze = 1'b0; stall_v = 1'b0; commit_v = 1'b0;
        pulse_snap();
        do_read(AW'(0), 3, 0);
        do_read(AW'(1), 0, 0);

        // reset while a response is outstanding
        rd_v = 1'b1; rd_addr = AW'(0);
        cyc();
        rd_v = 1'b0;
        check("pre_reset_valid", 32'(rd_data_v), 32'd1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        check("midread_reset_valid", 32'(rd_data_v), 32'd0);
        check("midread_reset_ready", 32'(rd_ready), 32'd1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            freeze = ($urandom_range(0, 7) == 0);
            commit_v = ($urandom_range(0, 1) == 1);
            stall_v = ($urandom_range(0, 1) == 1);
            stall_reason = RW'($urandom_range(0, (1 << RW) - 1));
            snap = ($urandom_range(0, 15) == 0);
            clear = ($urandom_range(0, 299) == 0);
            rd_v = ($urandom_range(0, 1) == 1);
            rd_addr = AW'($urandom_range(0, (1 << AW) - 1));
            rd_yumi = ($urandom_range(0, 1) == 1);
            reset_n = ($urandom_range(0, 999) != 0);
            cyc();
        end
        freeze = 1'b0; commit_v = 1'b0; stall_v = 1'b0; snap = 1'b0;
        clear = 1'b0; rd_v = 1'b0; rd_yumi = 1'b0; reset_n = 1'b1;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
